display_mux_lab2: RTL and testbench

Front-end stage that feeds the LED sum logic and drives the dual seven-segment display. It synchronizes both 4-bit switch banks into the clock domain and hands the synchronized values downstream to the LED adder. It also time-multiplexes the two nibbles onto one shared seven-segment decoder input, alternating the two common-anode enables with a blanking gap between digits to prevent ghosting.

---
 rtl/display_mux_lab2_if.sv | 21 ++
 rtl/display_mux_lab2.sv | 100 ++++++++++
 tb/tb_display_mux_lab2.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/display_mux_lab2_if.sv
// Switch-bank / display bundle between the board-side driver and the display mux.
// The mux takes the raw switches and returns synchronized nibbles plus the 7-seg drive.
interface display_mux_lab2_if;
  logic [3:0] switch1;
  logic [3:0] switch2;
  logic [3:0] s1_sync;
  logic [3:0] s2_sync;
  logic [3:0] digit_sel;
  logic [1:0] anode;
  logic       frame_tick;

  modport master (
    output switch1, switch2,
    input  s1_sync, s2_sync, digit_sel, anode, frame_tick
  );

  modport slave (
    input  switch1, switch2,
    output s1_sync, s2_sync, digit_sel, anode, frame_tick
  );
endinterface

// File: rtl/display_mux_lab2.sv
// Two-flop switch synchronizers plus a D0/B0/D1/B1 digit multiplexer for a dual common-anode display.
// Synced nibbles lag inputs by 2 clocks; free-running, no backpressure from downstream.
module display_mux_lab2 #(
  parameter int ON_CYCLES    = 24000,
  parameter int BLANK_CYCLES = 240,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  display_mux_lab2_if.slave bus_io
);

  typedef enum logic [1:0] {S_D0, S_B0, S_D1, S_B1} state_t;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam bit               NO_BLANK   = (BLANK_CYCLES == 0);

  logic [3:0]       s1_meta_q, s2_meta_q;
  logic [3:0]       s1_sync_q, s2_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       anode_q, anode_d;
  logic [3:0]       digit_sel_q, digit_sel_d;
  logic             adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_meta_q <= '0;
      s2_meta_q <= '0;
      s1_sync_q <= '0;
      s2_sync_q <= '0;
    end else begin
      s1_meta_q <= bus_io.switch1;
      s2_meta_q <= bus_io.switch2;
      s1_sync_q <= s1_meta_q;
      s2_sync_q <= s2_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_B1;
      count_q     <= '0;
      anode_q     <= 2'b11;
      digit_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      anode_q     <= anode_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adv         = 1'b0;
    anode_d     = 2'b11;
    digit_sel_d = digit_sel_q;

    case (state_q)
      S_D0: if (count_q == ON_LAST) begin
        adv     = 1'b1;
        state_d = NO_BLANK ? S_D1 : S_B0;
      end
      S_B0: if (count_q == BLANK_LAST) begin
        adv     = 1'b1;
        state_d = S_D1;
      end
      S_D1: if (count_q == ON_LAST) begin
        adv     = 1'b1;
        state_d = NO_BLANK ? S_D0 : S_B1;
      end
      S_B1: if (NO_BLANK || count_q == BLANK_LAST) begin
        // Without blanking the reset state is only a one-cycle launch point.
        adv     = 1'b1;
        state_d = S_D0;
      end
    endcase

    count_d = adv ? '0 : count_q + CNT_W'(1);

    case (state_d)
      S_D0:    anode_d = 2'b10;
      S_D1:    anode_d = 2'b01;
      default: anode_d = 2'b11;
    endcase

    // The lit nibble is latched on entry so mid-digit switch motion never shows.
    if (adv && state_d == S_D0) digit_sel_d = s1_sync_q;
    if (adv && state_d == S_D1) digit_sel_d = s2_sync_q;
  end

  assign bus_io.s1_sync    = s1_sync_q;
  assign bus_io.s2_sync    = s2_sync_q;
  assign bus_io.digit_sel  = digit_sel_q;
  assign bus_io.anode      = anode_q;
  assign bus_io.frame_tick = (state_q == S_D0) && (count_q == '0);

endmodule

// File: tb/tb_display_mux_lab2.sv
// Bench for display_mux_lab2: two instances (blanking and no-blanking) against a frame-position model.
module tb_display_mux_lab2;

  localparam int ON_A = 4;
  localparam int BL_A = 2;
  localparam int ON_B = 3;
  localparam int BL_B = 0;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] sw1, sw2;

  always #5 clk = ~clk;

  display_mux_lab2_if if_a ();
  display_mux_lab2_if if_b ();

  assign if_a.switch1 = sw1;
  assign if_a.switch2 = sw2;
  assign if_b.switch1 = sw1;
  assign if_b.switch2 = sw2;

  display_mux_lab2 #(.ON_CYCLES(ON_A), .BLANK_CYCLES(BL_A), .CNT_W(8)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .bus_io (if_a.slave)
  );

  display_mux_lab2 #(.ON_CYCLES(ON_B), .BLANK_CYCLES(BL_B), .CNT_W(8)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .bus_io (if_b.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: position within the frame as a pure function of edges since reset release.
  int         t;
  logic [3:0] h1[$];
  logic [3:0] h2[$];
  logic [3:0] dig_exp[2];

  function automatic int first_d0(input int b);
    return (b > 0) ? b : 1;
  endfunction

  function automatic logic [1:0] exp_an(input int tt, input int on, input int b);
    int p;
    if (tt < first_d0(b)) return 2'b11;
    p = (tt - first_d0(b)) % (2 * (on + b));
    if (p < on)          return 2'b10;
    if (p < on + b)      return 2'b11;
    if (p < 2 * on + b)  return 2'b01;
    return 2'b11;
  endfunction

  function automatic bit is_entry(input int tt, input int on, input int b, input bit d1);
    int p;
    if (tt < first_d0(b)) return 1'b0;
    p = (tt - first_d0(b)) % (2 * (on + b));
    return p == (d1 ? on + b : 0);
  endfunction

  function automatic logic [3:0] sync_after(input int tt, input bit second);
    if (tt < 2) return 4'h0;
    return second ? h2[tt-2] : h1[tt-2];
  endfunction

  task automatic model_edge();
    logic [3:0] p1, p2;
    t++;
    p1 = sync_after(t - 1, 1'b0);
    p2 = sync_after(t - 1, 1'b1);
    h1.push_back(sw1);
    h2.push_back(sw2);
    if (is_entry(t, ON_A, BL_A, 1'b0)) dig_exp[0] = p1;
    if (is_entry(t, ON_A, BL_A, 1'b1)) dig_exp[0] = p2;
    if (is_entry(t, ON_B, BL_B, 1'b0)) dig_exp[1] = p1;
    if (is_entry(t, ON_B, BL_B, 1'b1)) dig_exp[1] = p2;
  endtask

  task automatic check_outs(input string pfx, input int on, input int b, input int d,
                            input logic [1:0] an, input logic [3:0] ds, input logic ft,
                            input logic [3:0] s1, input logic [3:0] s2);
    check({pfx, "anode"},      an, exp_an(t, on, b));
    check({pfx, "digit_sel"},  ds, dig_exp[d]);
    check({pfx, "frame_tick"}, ft, is_entry(t, on, b, 1'b0));
    check({pfx, "s1_sync"},    s1, sync_after(t, 1'b0));
    check({pfx, "s2_sync"},    s2, sync_after(t, 1'b1));
  endtask

  task automatic check_rst(input string pfx, input logic [1:0] an, input logic [3:0] ds,
                           input logic ft, input logic [3:0] s1, input logic [3:0] s2);
    check({pfx, "rst_anode"},      an, 2'b11);
    check({pfx, "rst_digit_sel"},  ds, 4'h0);
    check({pfx, "rst_frame_tick"}, ft, 1'b0);
    check({pfx, "rst_s1_sync"},    s1, 4'h0);
    check({pfx, "rst_s2_sync"},    s2, 4'h0);
  endtask

  task automatic step(input int chg_pct);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs("A_", ON_A, BL_A, 0, if_a.anode, if_a.digit_sel, if_a.frame_tick, if_a.s1_sync, if_a.s2_sync);
    check_outs("B_", ON_B, BL_B, 1, if_b.anode, if_b.digit_sel, if_b.frame_tick, if_b.s1_sync, if_b.s2_sync);
    if (int'($urandom_range(99)) < chg_pct) sw1 = 4'($urandom_range(15));
    if (int'($urandom_range(99)) < chg_pct) sw2 = 4'($urandom_range(15));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check_rst("A_", if_a.anode, if_a.digit_sel, if_a.frame_tick, if_a.s1_sync, if_a.s2_sync);
      check_rst("B_", if_b.anode, if_b.digit_sel, if_b.frame_tick, if_b.s1_sync, if_b.s2_sync);
      sw1 = 4'($urandom_range(15));
      sw2 = 4'($urandom_range(15));
    end
    t = 0;
    h1.delete();
    h2.delete();
    dig_exp[0] = 4'h0;
    dig_exp[1] = 4'h0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    sw1   = 4'h0;
    sw2   = 4'h0;
    t     = 0;
    dig_exp[0] = 4'h0;
    dig_exp[1] = 4'h0;

    do_reset(4);

    sw1 = 4'hA;
    sw2 = 4'h3;
    repeat (26) step(0);

    // Change switch1 during the second lit cycle of digit 0 on the blanking instance.
    for (int i = 0; i < 24; i++) begin
      step(0);
      if (is_entry(t, ON_A, BL_A, 1'b0)) break;
    end
    step(0);
    sw1 = 4'h5;
    step(0);
    step(0);
    check("mid_s1_sync", if_a.s1_sync, 4'h5);
    repeat (14) step(0);

    sw1 = 4'hF;
    sw2 = 4'h1;
    step(0);
    step(0);
    check("led_sum", {1'b0, if_a.s1_sync} + {1'b0, if_a.s2_sync}, 5'h10);

    repeat (400) step(30);

    // Asynchronous reset between edges while the blanking instance shows digit 1.
    for (int i = 0; i < 24; i++) begin
      step(10);
      if (exp_an(t, ON_A, BL_A) == 2'b01) break;
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_anode",     if_a.anode, 2'b11);
    check("async_digit_sel", if_a.digit_sel, 4'h0);
    check("async_frame",     if_a.frame_tick, 1'b0);
    do_reset(3);
    repeat (40) step(20);
    repeat (300) step(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
